fast_window_gen: RTL

- Streaming sliding-window generator for the FAST corner pipeline.
- Takes a raster pixel stream (from the ARM DMA path), buffers WIN_SIZE-1 lines and emits one WIN_SIZE x WIN_SIZE window per accepted interior pixel, tagged with its centre coordinate.
- Downstream FAST segment-test and NMS stages consume win_data, x_coord and y_coord.
- Successor to the fixed-size FAST front end: window size, image size, pixel width and coordinate widths are parametrised, and it adds SOF resync and a frame-done pulse.

---
 rtl/fast_pkg.sv | 22 ++
 rtl/fast_line_buffer.sv | 34 +++
 rtl/fast_window_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fast_pkg.sv
// Shared defaults and helpers for the FAST window front end.
//   DEF_* : default image geometry, pixel width and derived coordinate widths.
//   win_radius(win_size) : R, the distance from the window centre to its edge.
//   idx(r, c, win_size)  : row-major element index inside a flattened window.
package fast_pkg;

  localparam int unsigned DEF_COL_NUM     = 640;
  localparam int unsigned DEF_ROW_NUM     = 480;
  localparam int unsigned DEF_PIXEL_WIDTH = 8;
  localparam int unsigned DEF_WIN_SIZE    = 7;
  localparam int unsigned DEF_X_WIDTH     = $clog2(DEF_COL_NUM);
  localparam int unsigned DEF_Y_WIDTH     = $clog2(DEF_ROW_NUM);

  function automatic int unsigned win_radius(int unsigned win_size);
    return (win_size - 1) / 2;
  endfunction

  function automatic int unsigned idx(int unsigned r, int unsigned c, int unsigned win_size);
    return r * win_size + c;
  endfunction

endpackage

// File: rtl/fast_line_buffer.sv
// One buffered image line: simple dual-port RAM with a registered read port.
//   clk, ce         : clock and global enable (ce low freezes reads and writes)
//   rd_addr/rd_data : synchronous read, data valid one ce-high cycle later
//   wr_en/wr_addr/wr_data : synchronous write
// A read and a write to the same address in one cycle return the old contents.
module fast_line_buffer
  import fast_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_COL_NUM,
  parameter int unsigned WIDTH = DEF_PIXEL_WIDTH,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fast_window_gen.sv
// Streaming WIN_SIZE x WIN_SIZE sliding-window generator.
//   clk, rst   : clock, asynchronous active-high reset
//   ce         : global enable, low freezes every register and RAM write
//   in_valid, in_sof, data_in : raster pixel stream; in_sof marks pixel (0,0)
//   win_valid, win_data       : window (row-major, top-left first)
//   x_coord, y_coord          : window centre coordinate
//   frame_done                : pulse with the output of the last frame pixel
// Pipeline: S0 accepts a pixel and reads the line buffers at its column; S1
// shifts the window left, loads the new right column and writes the column
// back down the line-buffer cascade. Outputs register at the end of S1.
module fast_window_gen
  import fast_pkg::*;
#(
  parameter int unsigned COL_NUM     = DEF_COL_NUM,
  parameter int unsigned ROW_NUM     = DEF_ROW_NUM,
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int unsigned WIN_SIZE    = DEF_WIN_SIZE,
  parameter int unsigned X_WIDTH     = DEF_X_WIDTH,
  parameter int unsigned Y_WIDTH     = DEF_Y_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     ce,
  input  logic                                     in_valid,
  input  logic                                     in_sof,
  input  logic [PIXEL_WIDTH-1:0]                   data_in,
  output logic                                     win_valid,
  output logic [WIN_SIZE*WIN_SIZE*PIXEL_WIDTH-1:0] win_data,
  output logic [X_WIDTH-1:0]                       x_coord,
  output logic [Y_WIDTH-1:0]                       y_coord,
  output logic                                     frame_done
);

  localparam int unsigned R     = win_radius(WIN_SIZE);
  localparam int unsigned NLB   = WIN_SIZE - 1;
  localparam int unsigned AW    = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int unsigned WIN_W = WIN_SIZE * WIN_SIZE * PIXEL_WIDTH;
  localparam int unsigned PW    = PIXEL_WIDTH;

  // Position counters for the next pixel to be accepted.
  logic [X_WIDTH-1:0] col_q, col_d, cur_col;
  logic [Y_WIDTH-1:0] row_q, row_d, cur_row;
  logic               cur_last;

  // S1 pixel.
  logic               v1_q;
  logic [PW-1:0]      pix1_q;
  logic [X_WIDTH-1:0] col1_q;
  logic [Y_WIDTH-1:0] row1_q;
  logic               last1_q;

  logic [PW-1:0]      lb_rd [NLB];
  logic [PW-1:0]      lb_wr [NLB];
  logic               lb_we;
  logic [AW-1:0]      rd_addr;

  logic [WIN_W-1:0]   win_q, win_d;
  logic               win_ok;
  logic               win_valid_q, frame_done_q;
  logic [X_WIDTH-1:0] x_q;
  logic [Y_WIDTH-1:0] y_q;

  // SOF overrides the running position so the accepted pixel becomes (0,0).
  always_comb begin
    cur_col  = in_sof ? '0 : col_q;
    cur_row  = in_sof ? '0 : row_q;
    cur_last = (cur_col == X_WIDTH'(COL_NUM - 1)) && (cur_row == Y_WIDTH'(ROW_NUM - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (ce && in_valid) begin
      if (cur_col == X_WIDTH'(COL_NUM - 1)) begin
        col_d = '0;
        row_d = (cur_row == Y_WIDTH'(ROW_NUM - 1)) ? '0 : cur_row + Y_WIDTH'(1);
      end else begin
        col_d = cur_col + X_WIDTH'(1);
        row_d = cur_row;
      end
    end
  end

  assign rd_addr = cur_col[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      v1_q    <= 1'b0;
      pix1_q  <= '0;
      col1_q  <= '0;
      row1_q  <= '0;
      last1_q <= 1'b0;
    end else if (ce) begin
      col_q <= col_d;
      row_q <= row_d;
      v1_q  <= in_valid;
      if (in_valid) begin
        pix1_q  <= data_in;
        col1_q  <= cur_col;
        row1_q  <= cur_row;
        last1_q <= cur_last;
      end
    end
  end

  // Line-buffer cascade: lb[0] holds the previous row, lb[k] the row k+1 above.
  assign lb_we = ce & v1_q;

  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign lb_wr[k] = pix1_q;
    end else begin : g_cascade
      assign lb_wr[k] = lb_rd[k-1];
    end

    fast_line_buffer #(
      .DEPTH (COL_NUM),
      .WIDTH (PIXEL_WIDTH)
    ) u_lb (
      .clk     (clk),
      .ce      (ce),
      .rd_addr (rd_addr),
      .rd_data (lb_rd[k]),
      .wr_en   (lb_we),
      .wr_addr (col1_q[AW-1:0]),
      .wr_data (lb_wr[k])
    );
  end

  // Shift left one column; the right column is oldest line at the top down to
  // the S1 pixel at the bottom.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < WIN_SIZE; r++) begin
      for (int c = 0; c < WIN_SIZE - 1; c++) begin
        win_d[idx(r, c, WIN_SIZE)*PW +: PW] = win_q[idx(r, c + 1, WIN_SIZE)*PW +: PW];
      end
    end
    for (int r = 0; r < WIN_SIZE - 1; r++) begin
      win_d[idx(r, WIN_SIZE - 1, WIN_SIZE)*PW +: PW] = lb_rd[WIN_SIZE - 2 - r];
    end
    win_d[idx(WIN_SIZE - 1, WIN_SIZE - 1, WIN_SIZE)*PW +: PW] = pix1_q;
  end

  assign win_ok = v1_q && (col1_q >= X_WIDTH'(WIN_SIZE - 1))
                       && (row1_q >= Y_WIDTH'(WIN_SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else if (ce) begin
      win_valid_q  <= win_ok;
      frame_done_q <= v1_q & last1_q;
      if (v1_q) begin
        win_q <= win_d;
      end
      if (win_ok) begin
        x_q <= col1_q - X_WIDTH'(R);
        y_q <= row1_q - Y_WIDTH'(R);
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_q;
  assign x_coord    = x_q;
  assign y_coord    = y_q;
  assign frame_done = frame_done_q;

endmodule
